// File: rtl/dram_write_control.sv
// Ring-buffer DRAM capture writer: wraps until triggered, then writes POST_TRIG more words and stops; WR_DROP_CNT_EN adds drop_cnt.
// Write command is raised the cycle after a word is captured; din_ready is low while a command waits for dram_ready.
module dram_write_control #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 144,
    parameter int DEPTH     = 1 << ADDR_W,
    parameter int POST_TRIG = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              trig,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_data,
    output logic              dram_cmd_valid,
    output logic              dram_rwn,
    input  logic              dram_ready,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              wrapped,
    output logic              done,
    output logic              overflow,
    output logic [1:0]        state
`ifdef WR_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   POST_LIM  = (ADDR_W+1)'(POST_TRIG);
    localparam bit                POST_ZERO = (POST_TRIG == 0);

    state_t              cur, nxt;
    logic [ADDR_W-1:0]   ptr;
    logic                triggered;
    logic [ADDR_W:0]     post_cnt, post_nxt;
    logic                start, take, accept, trig_hit, drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= IDLE;
        else      cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        start    = 1'b0;
        take     = 1'b0;
        accept   = 1'b0;
        trig_hit = 1'b0;
        drop     = 1'b0;
        post_nxt = post_cnt;
        case (cur)
            IDLE: if (en) begin
                nxt   = CAPT;
                start = 1'b1;
            end
            CAPT: begin
                trig_hit = trig && !triggered;
                if (!en)                        nxt = IDLE;
                else if (trig_hit && POST_ZERO) nxt = DONE;
                else if (din_valid) begin
                    take = 1'b1;
                    nxt  = ISSUE;
                end
            end
            ISSUE: begin
                trig_hit = trig && !triggered;
                drop     = din_valid;
                if (trig_hit && POST_ZERO) nxt = DONE;
                else if (dram_ready) begin
                    accept = 1'b1;
                    // A trigger arriving with the acceptance makes this word post-trigger word 1
                    if (triggered || trig_hit) post_nxt = post_cnt + (ADDR_W+1)'(1);
                    if ((triggered || trig_hit) && post_nxt == POST_LIM) nxt = DONE;
                    else if (!en)                                        nxt = IDLE;
                    else                                                 nxt = CAPT;
                end
            end
            DONE: if (!en) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            dram_data <= '0;
            trig_addr <= '0;
            triggered <= 1'b0;
            post_cnt  <= '0;
            wrapped   <= 1'b0;
            overflow  <= 1'b0;
`ifdef WR_DROP_CNT_EN
            drop_cnt  <= '0;
`endif
        end else if (start) begin
            ptr       <= '0;
            trig_addr <= '0;
            triggered <= 1'b0;
            post_cnt  <= '0;
            wrapped   <= 1'b0;
            overflow  <= 1'b0;
`ifdef WR_DROP_CNT_EN
            drop_cnt  <= '0;
`endif
        end else begin
            if (take) dram_data <= din;
            if (trig_hit) begin
                triggered <= 1'b1;
                trig_addr <= ptr;
            end
            if (accept) begin
                post_cnt <= post_nxt;
                if (ptr == PTR_LAST) begin
                    ptr     <= '0;
                    wrapped <= 1'b1;
                end else begin
                    ptr <= ptr + ADDR_W'(1);
                end
            end
            if (drop) overflow <= 1'b1;
`ifdef WR_DROP_CNT_EN
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
        end
    end

    assign din_ready      = (cur == CAPT);
    assign dram_cmd_valid = (cur == ISSUE);
    assign done           = (cur == DONE);
    assign dram_addr      = ptr;
    assign dram_rwn       = 1'b0;
    assign state          = cur;

endmodule

// File: tb/tb_dram_write_control.sv
// Randomized and directed bench for dram_write_control against a word-level capture model.
`timescale 1ns/1ps
module tb_dram_write_control;
    localparam int AW = 4, DW = 16, DEP = 16, PT = 4;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0, trig = 1'b0, din_valid = 1'b0, dram_ready = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_ready, dram_cmd_valid, dram_rwn, wrapped, done, overflow;
    logic [AW-1:0] dram_addr, trig_addr;
    logic [DW-1:0] dram_data;
    logic [1:0]    state;
    logic          din_ready1, dram_cmd_valid1, dram_rwn1, wrapped1, done1, overflow1;
    logic [AW-1:0] dram_addr1, trig_addr1;
    logic [DW-1:0] dram_data1;
    logic [1:0]    state1;
`ifdef WR_DROP_CNT_EN
    logic [15:0]   drop_cnt, drop_cnt1;
`endif

    dram_write_control #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .POST_TRIG(PT)) dut (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dram_addr(dram_addr), .dram_data(dram_data),
        .dram_cmd_valid(dram_cmd_valid), .dram_rwn(dram_rwn), .dram_ready(dram_ready),
        .trig_addr(trig_addr), .wrapped(wrapped), .done(done), .overflow(overflow), .state(state)
`ifdef WR_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    dram_write_control #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .POST_TRIG(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .din(din), .din_valid(din_valid),
        .din_ready(din_ready1), .dram_addr(dram_addr1), .dram_data(dram_data1),
        .dram_cmd_valid(dram_cmd_valid1), .dram_rwn(dram_rwn1), .dram_ready(dram_ready),
        .trig_addr(trig_addr1), .wrapped(wrapped1), .done(done1), .overflow(overflow1), .state(state1)
`ifdef WR_DROP_CNT_EN
        , .drop_cnt(drop_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Word-level model: run = capturing, hold = a word awaits its write, wr = writes since arm
    bit m_run, m_hold, m_done, m_trg, m_ovf, m_wrapped;
    int m_wr, m_post, m_drops;
    logic [AW-1:0] m_tadr;
    logic [DW-1:0] m_hdata;
    bit exp_wr, obs_wr;
    logic [AW-1:0] exp_waddr, obs_addr;
    logic [DW-1:0] exp_wdata, obs_data;

    task automatic model_clear();
        m_run = 0; m_hold = 0; m_done = 0; m_trg = 0; m_ovf = 0; m_wrapped = 0;
        m_wr = 0; m_post = 0; m_drops = 0; m_tadr = '0; m_hdata = '0;
    endtask

    task automatic model_step();
        bit t_now;
        exp_wr = 0;
        if (m_done) begin
            if (!en) m_done = 0;
        end else if (!m_run) begin
            if (en) begin
                model_clear();
                m_run = 1;
            end
        end else begin
            if (m_hold && din_valid) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
            t_now = trig && !m_trg;
            if (t_now) begin
                m_trg  = 1;
                m_tadr = AW'(m_wr % DEP);
            end
            if (!m_hold) begin
                if (!en) m_run = 0;
                else if (din_valid) begin
                    m_hold  = 1;
                    m_hdata = din;
                end
            end else if (dram_ready) begin
                exp_wr    = 1;
                exp_waddr = AW'(m_wr % DEP);
                exp_wdata = m_hdata;
                m_wr++;
                if (m_wr >= DEP) m_wrapped = 1;
                m_hold = 0;
                if (m_trg) m_post++;
                if (m_trg && m_post == PT) begin
                    m_run  = 0;
                    m_done = 1;
                end else if (!en) m_run = 0;
            end
        end
    endtask

    task automatic cyc();
        obs_wr   = dram_cmd_valid && dram_ready;
        obs_addr = dram_addr;
        obs_data = dram_data;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 0; en = 0; trig = 0; din_valid = 0; dram_ready = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 0; en = 1; din_valid = 1; dram_ready = 1;
        #1;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if ({dram_cmd_valid, din_ready, done} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {dram_cmd_valid, din_ready, done}); end
        checks++; if ({wrapped, overflow, dram_rwn} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {wrapped, overflow, dram_rwn}); end
        checks++; if ({dram_addr, trig_addr, dram_data} !== '0) begin failures++; $display("FAIL reset_regs got=%0h/%0h/%0h exp=0", dram_addr, trig_addr, dram_data); end
        do_reset();
        cyc();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_wait got=%0d exp=0", state); end
    endtask

    // Continuous flow; trigger while the word at write index pre is pending
    task automatic test_trigger(input int pre, input int exp_tadr, input bit exp_wrap, input int exp_nw);
        int nw, last; bit seen_wrap;
        nw = 0; last = -1; seen_wrap = 0;
        do_reset();
        en = 1; din_valid = 1; dram_ready = 1;
        for (int c = 0; c < 400 && !done; c++) begin
            din  = DW'($urandom);
            trig = m_hold && (m_wr == pre);
            cyc();
            if (obs_wr) begin
                checks++;
                if (obs_addr !== exp_waddr || obs_data !== exp_wdata) begin
                    failures++; $display("FAIL trig_write got=%0h:%0h exp=%0h:%0h", obs_addr, obs_data, exp_waddr, exp_wdata);
                end
                if (last == DEP - 1 && obs_addr == 0) seen_wrap = 1;
                last = obs_addr; nw++;
            end
        end
        trig = 0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL trig_done got=%b exp=1 (timeout)", done); end
        checks++; if (trig_addr !== AW'(exp_tadr)) begin failures++; $display("FAIL trig_addr got=%0d exp=%0d", trig_addr, exp_tadr); end
        checks++; if (wrapped !== exp_wrap) begin failures++; $display("FAIL trig_wrapped got=%b exp=%b", wrapped, exp_wrap); end
        checks++; if (nw != exp_nw || last != (exp_tadr + PT - 1) % DEP) begin failures++; $display("FAIL trig_writes got=%0d last=%0d exp=%0d last=%0d", nw, last, exp_nw, (exp_tadr + PT - 1) % DEP); end
        checks++; if (seen_wrap != exp_wrap) begin failures++; $display("FAIL trig_addr_wrap got=%b exp=%b", seen_wrap, exp_wrap); end
        din_valid = 0; dram_ready = 0;
        cyc(); cyc();
        checks++; if ({done, din_ready, dram_cmd_valid} !== 3'b100) begin failures++; $display("FAIL done_hold got=%b exp=100", {done, din_ready, dram_cmd_valid}); end
    endtask

    task automatic test_same_cycle();
        bit hit; int nw, last;
        hit = 0; nw = 0; last = -1;
        do_reset();
        en = 1; din_valid = 1; dram_ready = 1;
        for (int c = 0; c < 100; c++) begin
            if (m_hold && m_wr == 7) begin hit = 1; break; end
            din = DW'($urandom);
            cyc();
        end
        checks++; if (!hit || dram_addr !== AW'(7) || dram_cmd_valid !== 1'b1) begin failures++; $display("FAIL same_setup got=%0d/%b exp=7/1", dram_addr, dram_cmd_valid); end
        trig = 1;
        cyc();
        trig = 0;
        checks++; if (trig_addr !== AW'(7) || trig_addr1 !== AW'(7)) begin failures++; $display("FAIL same_taddr got=%0d/%0d exp=7/7", trig_addr, trig_addr1); end
        checks++; if (done1 !== 1'b1 || state1 !== 2'd3 || done !== 1'b0) begin failures++; $display("FAIL same_done got=%b/%0d/%b exp=1/3/0", done1, state1, done); end
        for (int c = 0; c < 50 && !done; c++) begin
            din = DW'($urandom);
            cyc();
            if (obs_wr) begin last = obs_addr; nw++; end
        end
        checks++; if (done !== 1'b1 || nw != 3 || last != 10) begin failures++; $display("FAIL same_post got=%b/%0d/%0d exp=1/3/10", done, nw, last); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] v;
        do_reset();
        en = 1; cyc();
        v = DW'($urandom);
        din = v; din_valid = 1; dram_ready = 0; cyc();
        for (int c = 0; c < 5; c++) begin
            din = DW'($urandom);
            cyc();
            checks++;
            if (dram_cmd_valid !== 1'b1 || dram_addr !== '0 || dram_data !== v) begin
                failures++; $display("FAIL stall_hold got=%b/%0h/%0h exp=1/0/%0h", dram_cmd_valid, dram_addr, dram_data, v);
            end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL stall_ovf got=%b exp=1", overflow); end
`ifdef WR_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd5) begin failures++; $display("FAIL stall_drops got=%0d exp=5", drop_cnt); end
`endif
        din_valid = 0; dram_ready = 1; cyc();
        checks++; if (obs_wr !== 1'b1 || obs_data !== v || state !== 2'd1) begin failures++; $display("FAIL stall_accept got=%b/%0h/%0d exp=1/%0h/1", obs_wr, obs_data, state, v); end
    endtask

    task automatic test_en_drop();
        do_reset();
        en = 1; cyc();
        din = 16'hBEEF; din_valid = 1; dram_ready = 0; cyc();
        din_valid = 0; en = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if (dram_cmd_valid !== 1'b1 || state !== 2'd2) begin failures++; $display("FAIL endrop_wait got=%b/%0d exp=1/2", dram_cmd_valid, state); end
        end
        dram_ready = 1; cyc();
        checks++; if (obs_wr !== 1'b1 || obs_data !== 16'hBEEF) begin failures++; $display("FAIL endrop_write got=%b/%0h exp=1/beef", obs_wr, obs_data); end
        checks++; if (state !== 2'd0 || done !== 1'b0) begin failures++; $display("FAIL endrop_idle got=%0d/%b exp=0/0", state, done); end
    endtask

    task automatic test_reset_mid();
        int writes;
        writes = 0;
        do_reset();
        en = 1; cyc();
        din = 16'h1234; din_valid = 1; dram_ready = 0; cyc();
        din_valid = 0; cyc();
        #2 rst = 0;
        #1;
        checks++; if (dram_cmd_valid !== 1'b0 || state !== 2'd0) begin failures++; $display("FAIL rstmid_async got=%b/%0d exp=0/0", dram_cmd_valid, state); end
        @(negedge clk);
        rst = 1; model_clear();
        en = 0; din_valid = 1; dram_ready = 1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (dram_cmd_valid || state != 2'd0) writes++;
        end
        checks++; if (writes != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", writes); end
        en = 1; din_valid = 0; cyc();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL rstmid_rearm got=%0d exp=1", state); end
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                en         = ($urandom_range(0, 19) != 0);
                trig       = ($urandom_range(0, 29) == 0);
                din_valid  = ($urandom_range(0, 9) < 7);
                dram_ready = ($urandom_range(0, 9) < 6);
                din        = DW'($urandom);
                cyc();
                checks++;
                if (obs_wr !== exp_wr || (exp_wr && (obs_addr !== exp_waddr || obs_data !== exp_wdata))) begin
                    failures++; $display("FAIL rnd_write got=%b:%0h:%0h exp=%b:%0h:%0h", obs_wr, obs_addr, obs_data, exp_wr, exp_waddr, exp_wdata);
                end
                checks++;
                if ({done, dram_cmd_valid, din_ready} !== {m_done, m_hold, m_run && !m_hold}) begin
                    failures++; $display("FAIL rnd_ctrl got=%b exp=%b", {done, dram_cmd_valid, din_ready}, {m_done, m_hold, m_run && !m_hold});
                end
                checks++;
                if ({overflow, wrapped} !== {m_ovf, m_wrapped} || trig_addr !== m_tadr) begin
                    failures++; $display("FAIL rnd_flags got=%b/%0d exp=%b/%0d", {overflow, wrapped}, trig_addr, {m_ovf, m_wrapped}, m_tadr);
                end
`ifdef WR_DROP_CNT_EN
                checks++;
                if (drop_cnt !== 16'(m_drops)) begin failures++; $display("FAIL rnd_drops got=%0d exp=%0d", drop_cnt, m_drops); end
`endif
            end
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_trigger(9, 9, 1'b0, 13);
        test_trigger(20, 4, 1'b1, 24);
        test_same_cycle();
        test_stall();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
